key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 144 ++++++++++++++
 tb/tb_key_conditioner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Per-key synchronizer, debouncer, press/release edge pulses and
// auto-repeat strobe generator; all outputs registered.
module key_conditioner #(
    parameter int n_keys            = 4,
    parameter int debounce_depth    = 16,
    parameter int active_low_inputs = 1,
    parameter int repeat_delay      = 500000,
    parameter int repeat_period     = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [n_keys-1:0] key_raw,
    input  logic              repeat_enable,
    output logic [n_keys-1:0] pressed,
    output logic [n_keys-1:0] press,
    // release is a reserved word, hence the suffix
    output logic [n_keys-1:0] release_pulse,
    output logic [n_keys-1:0] repeat_strobe,
    output logic              any_pressed
);

    localparam int DW   = $clog2(debounce_depth + 1);
    localparam int RMAX = (repeat_delay > repeat_period) ?
                          repeat_delay : repeat_period;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_DELAY,
        R_PERIOD
    } rep_state_t;

    logic [n_keys-1:0] polar;
    logic [n_keys-1:0] sync1;
    logic [n_keys-1:0] sync2;
    logic [n_keys-1:0] tog;
    logic [n_keys-1:0] rise;
    logic [n_keys-1:0] fall;
    logic [n_keys-1:0] stb;
    logic [n_keys-1:0] pressed_nxt;

    logic [DW-1:0] db_cnt [n_keys];
    logic [DW-1:0] db_nxt [n_keys];
    logic [RW-1:0] rc     [n_keys];
    logic [RW-1:0] rc_nxt [n_keys];
    logic [RW-1:0] rc_inc [n_keys];
    rep_state_t    st     [n_keys];
    rep_state_t    st_nxt [n_keys];

    // Polarity is folded in ahead of the flops so that the cleared
    // synchronizer state reads as "not pressed".
    assign polar = (active_low_inputs != 0) ? ~key_raw : key_raw;

    always_comb begin
        tog = '0;
        for (int i = 0; i < n_keys; i++) begin
            db_nxt[i] = '0;
            if (sync2[i] != pressed[i]) begin
                if (db_cnt[i] == DW'(debounce_depth - 1))
                    tog[i] = 1'b1;
                else
                    db_nxt[i] = db_cnt[i] + DW'(1);
            end
        end
        rise        = tog & ~pressed;
        fall        = tog & pressed;
        pressed_nxt = pressed ^ tog;
    end

    always_comb begin
        stb = '0;
        for (int i = 0; i < n_keys; i++) begin
            st_nxt[i] = st[i];
            rc_nxt[i] = rc[i];
            rc_inc[i] = rc[i] + RW'(1);
            if (rise[i]) begin
                stb[i]    = 1'b1;
                rc_nxt[i] = '0;
                st_nxt[i] = repeat_enable ? R_DELAY : R_IDLE;
            end else if (fall[i] || !repeat_enable) begin
                st_nxt[i] = R_IDLE;
                rc_nxt[i] = '0;
            end else begin
                unique case (st[i])
                    R_IDLE: begin
                        rc_nxt[i] = '0;
                    end
                    R_DELAY: begin
                        if (rc_inc[i] == RW'(repeat_delay)) begin
                            stb[i]    = 1'b1;
                            rc_nxt[i] = '0;
                            st_nxt[i] = R_PERIOD;
                        end else begin
                            rc_nxt[i] = rc_inc[i];
                        end
                    end
                    R_PERIOD: begin
                        if (rc_inc[i] == RW'(repeat_period)) begin
                            stb[i]    = 1'b1;
                            rc_nxt[i] = '0;
                        end else begin
                            rc_nxt[i] = rc_inc[i];
                        end
                    end
                    default: begin
                        st_nxt[i] = R_IDLE;
                        rc_nxt[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1         <= '0;
            sync2         <= '0;
            pressed       <= '0;
            press         <= '0;
            release_pulse <= '0;
            repeat_strobe <= '0;
            any_pressed   <= 1'b0;
            for (int i = 0; i < n_keys; i++) begin
                db_cnt[i] <= '0;
                rc[i]     <= '0;
                st[i]     <= R_IDLE;
            end
        end else begin
            sync1         <= polar;
            sync2         <= sync1;
            pressed       <= pressed_nxt;
            press         <= rise;
            release_pulse <= fall;
            repeat_strobe <= stb;
            any_pressed   <= |pressed_nxt;
            for (int i = 0; i < n_keys; i++) begin
                db_cnt[i] <= db_nxt[i];
                rc[i]     <= rc_nxt[i];
                st[i]     <= st_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key
// activity, every cycle compared with a window/offset reference model.
module tb_key_conditioner;

    localparam int NK  = 4;
    localparam int DEP = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_raw;
    logic          repeat_enable;
    logic [NK-1:0] pressed;
    logic [NK-1:0] press;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] repeat_strobe;
    logic          any_pressed;

    int n_checks = 0;
    int n_errors = 0;

    key_conditioner #(
        .n_keys(NK),
        .debounce_depth(DEP),
        .active_low_inputs(1),
        .repeat_delay(RD),
        .repeat_period(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_raw(key_raw),
        .repeat_enable(repeat_enable),
        .pressed(pressed),
        .press(press),
        .release_pulse(release_pulse),
        .repeat_strobe(repeat_strobe),
        .any_pressed(any_pressed)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [NK-1:0] samp_q [$];
    bit            hq [NK][$];
    logic [NK-1:0] m_pressed, m_press, m_rel, m_stb;
    int            t0 [NK];
    bit            armed [NK];
    int            edge_no;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     tag, got, exp, edge_no);
        end
    endtask

    task automatic model_reset();
        samp_q.delete();
        samp_q.push_back('0);
        samp_q.push_back('0);
        for (int i = 0; i < NK; i++) begin
            hq[i].delete();
            armed[i] = 0;
            t0[i]    = 0;
        end
        m_pressed = '0;
        m_press   = '0;
        m_rel     = '0;
        m_stb     = '0;
        edge_no   = 0;
    endtask

    task automatic model_step();
        logic [NK-1:0] lev;
        bit            flip;
        int            d;
        if (!reset) return;
        edge_no++;
        lev = samp_q.pop_front();
        samp_q.push_back(~key_raw);
        m_press = '0;
        m_rel   = '0;
        m_stb   = '0;
        for (int i = 0; i < NK; i++) begin
            hq[i].push_back(lev[i]);
            if (hq[i].size() > DEP) void'(hq[i].pop_front());
            flip = (hq[i].size() == DEP);
            foreach (hq[i][k])
                if (hq[i][k] == m_pressed[i]) flip = 0;
            if (flip && !m_pressed[i]) begin
                m_press[i]   = 1'b1;
                m_stb[i]     = 1'b1;
                t0[i]        = edge_no;
                armed[i]     = repeat_enable;
                m_pressed[i] = 1'b1;
            end else if (flip) begin
                m_rel[i]     = 1'b1;
                armed[i]     = 0;
                m_pressed[i] = 1'b0;
            end else if (!repeat_enable) begin
                armed[i] = 0;
            end else if (m_pressed[i] && armed[i]) begin
                d = edge_no - t0[i];
                if (d == RD || (d > RD && (d - RD) % RP == 0))
                    m_stb[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        chk("pressed", 32'(pressed), 32'(m_pressed));
        chk("press", 32'(press), 32'(m_press));
        chk("release", 32'(release_pulse), 32'(m_rel));
        chk("repeat_strobe", 32'(repeat_strobe), 32'(m_stb));
        chk("any_pressed", 32'(any_pressed), 32'(|m_pressed));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic async_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
    endtask

    int cnt;
    int waited;

    initial begin
        reset         = 1'b0;
        key_raw       = 4'h0;
        repeat_enable = 1'b1;
        model_reset();
        #1;
        compare_all();
        run(3);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (edge_no == 5) chk("edge5_press", 32'(press), 0);
            if (edge_no == 6) chk("edge6_press", 32'(press), 32'hF);
            if (edge_no == 6) chk("edge6_pressed", 32'(pressed), 32'hF);
        end

        key_raw = 4'hF;
        run(12);

        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) key_raw[0] = ~key_raw[0];
            cycle();
            cnt += int'(press[0]);
        end
        key_raw[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            cnt += int'(press[0]);
        end
        chk("bounce_one_press", 32'(cnt), 1);

        key_raw = 4'hF;
        run(12);
        cnt = 0;
        key_raw[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            cnt += int'(press[1] | release_pulse[1] | pressed[1]);
        end
        key_raw[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            cnt += int'(press[1] | release_pulse[1] | pressed[1]);
        end
        chk("glitch_rejected", 32'(cnt), 0);

        key_raw[1] = 1'b0;
        waited = 0;
        while (!pressed[1] && waited < 20) begin
            cycle();
            waited++;
        end
        chk("hold_rise_seen", 32'(pressed[1]), 1);
        cnt = int'(repeat_strobe[1]);
        for (int i = 1; i <= 30; i++) begin
            cycle();
            cnt += int'(repeat_strobe[1]);
        end
        chk("hold_strobes", 32'(cnt), 8);
        key_raw[1] = 1'b1;
        run(12);

        key_raw[1] = 1'b0;
        waited = 0;
        while (!pressed[1] && waited < 20) begin
            cycle();
            waited++;
        end
        run(12);
        @(negedge clk);
        async_reset();
        run(2);
        @(negedge clk);
        reset = 1'b1;
        run(20);

        key_raw = 4'hF;
        run(12);
        key_raw[0] = 1'b0;
        key_raw[2] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (press != 0) begin
                chk("simul_press", 32'(press), 32'h5);
                chk("simul_any", 32'(any_pressed), 1);
                cnt++;
            end
        end
        chk("simul_once", 32'(cnt), 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0)
                key_raw[$urandom_range(NK - 1)] ^= 1'b1;
            if ($urandom_range(63) == 0)
                repeat_enable = ~repeat_enable;
            if ($urandom_range(499) == 0) begin
                async_reset();
                cycle();
                reset = 1'b1;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
